// File: rtl/mem_responder.sv
// Fixed-latency word memory responder for the multicycle datapath's shared instruction/data port.
// Serves one request at a time and holds the captured request, so requester inputs are free once accepted.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              reqWe_q, reqWe_d;
  logic [IdxW+1:0]   reqAddr_q, reqAddr_d;
  logic [31:0]       reqWdata_q, reqWdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];

  logic              accessNow;
  logic              misaligned;
  logic [IdxW-1:0]   wordIdx;
  logic              unusedAddrHi;

  // Address bits above the word index are dropped, so accesses wrap modulo DEPTH*4.
  assign unusedAddrHi = ^addr_i[31:IdxW+2];
  assign wordIdx      = reqAddr_q[IdxW+1:2];
  assign misaligned   = (reqAddr_q[1:0] != 2'b00);
  assign accessNow    = (state_q == StWait) && (cnt_q == 4'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reqWe_d    = reqWe_q;
    reqAddr_d  = reqAddr_q;
    reqWdata_d = reqWdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          reqWe_d    = we_i;
          reqAddr_d  = addr_i[IdxW+1:0];
          reqWdata_d = wdata_i;
          cnt_d      = 4'(LATENCY);
          err_d      = 1'b0;
          state_d    = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          err_d   = misaligned;
          if (!reqWe_q && !misaligned) begin
            rdata_d = mem_q[wordIdx];
          end
        end
      end
      StResp: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      reqWe_q    <= 1'b0;
      reqAddr_q  <= '0;
      reqWdata_q <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reqWe_q    <= reqWe_d;
      reqAddr_q  <= reqAddr_d;
      reqWdata_q <= reqWdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately not cleared by reset; reset only blocks a write that is in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_i && accessNow && reqWe_q && !misaligned) begin
      mem_q[wordIdx] <= reqWdata_q;
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign ready_o = (state_q == StResp);
  assign busy_o  = (state_q != StIdle);

endmodule
